// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus memory bus of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_read, mem_write, mem_funct3, mem_write_data
    );
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_read, mem_write, mem_funct3, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sequences RV32I loads/stores to the 8 kB memory/peripheral block.
// LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of aligning them down.
module load_store_unit (
    input logic clk,
    input logic reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_t;
    state_t state;
    logic resp_valid, resp_error, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data;
    logic [2:0] mem_funct3;
    logic [2:0] f;
    logic legal, err;
    logic [31:0] addr, w, ext;
    logic [1:0] a;
    logic [7:0] b;
    logic [15:0] h;
    assign f = bus.req_funct3;
    assign legal = f[1:0] != 2'b11 && (bus.req_write ? !f[2] : !(f[2] && f[1]));
`ifdef LSU_MISALIGN_TRAP_EN
    assign err = !legal || (f[0] && bus.req_addr[0]) || (f[1] && bus.req_addr[1:0] != 2'b00);
    assign addr = bus.req_addr;
`else
    assign err = !legal;
    assign addr = {bus.req_addr[31:2], bus.req_addr[1] & ~f[1], bus.req_addr[0] & ~f[1] & ~f[0]};
`endif
    // Lane extraction uses the registered (possibly aligned) address and size.
    assign a = mem_address[1:0];
    assign w = bus.mem_read_data;
    assign b = w[{a, 3'b000} +: 8];
    assign h = a[1] ? w[31:16] : w[15:0];
    assign ext = mem_funct3[1] ? w :
                 mem_funct3[0] ? {{16{~mem_funct3[2] & h[15]}}, h} :
                                 {{24{~mem_funct3[2] & b[7]}}, b};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_address <= '0;
            mem_funct3 <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    mem_address <= addr;
                    mem_funct3 <= f;
                    mem_write_data <= bus.req_wdata;
                    if (err) begin
                        state <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                    end else if (bus.req_write) begin
                        state <= WR;
                        mem_write <= 1'b1;
                    end else begin
                        state <= RD_ADDR;
                        mem_read <= 1'b1;
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    state <= RESP;
                    mem_read <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= ext;
                end
                WR: begin
                    state <= RESP;
                    mem_write <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: if (bus.resp_ready) begin
                    state <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.req_ready = state == IDLE && !reset;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_error = resp_error;
    assign bus.resp_rdata = resp_rdata;
    assign bus.mem_read = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_address = mem_address;
    assign bus.mem_funct3 = mem_funct3;
    assign bus.mem_write_data = mem_write_data;
endmodule
